rx_data_sampler: RTL and testbench

RX_DATA_SAMPLER -- requirements
Module: rx_data_sampler

---
 rtl/uart_rx_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/rx_data_sampler.sv | 127 ++++++++++++
 tb/tb_rx_data_sampler.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART receive path: bus width defaults, line idle level,
// the legal oversampling ratios and the three-input majority vote used by the sampler.
package uart_rx_pkg;

   localparam int PWIDTH_DEF  = 6;
   localparam int BCWIDTH_DEF = 4;

   localparam logic IDLE_LEVEL = 1'b1;

   typedef enum int {
      PRESCALE_X8  = 8,
      PRESCALE_X16 = 16,
      PRESCALE_X32 = 32
   } prescale_e;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; both flops reset to RESET_VAL
// so the output reads the line's idle level straight out of reset.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic data_i,
   output logic data_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= data_i;
         sync_q <= meta_q;
      end
   end

   assign data_o = sync_q;

endmodule

// File: rtl/rx_data_sampler.sv
// UART receive oversampler: tracks position within a bit, counts bit periods and
// decides each bit around mid-bit. Define RX_MAJORITY_VOTE_EN for a 3-sample majority vote.
module rx_data_sampler
   import uart_rx_pkg::*;
#(
   parameter int PWIDTH  = PWIDTH_DEF,
   parameter int BCWIDTH = BCWIDTH_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic               rx_in,
   input  logic [PWIDTH-1:0]  prescale,
   output logic               rx_sync,
   output logic [PWIDTH-1:0]  edge_counter,
   output logic [BCWIDTH-1:0] bit_counter,
   output logic               sampled_bit,
   output logic               bit_done
);

   logic               rxSync;
   logic [PWIDTH-1:0]  edgeLast;
   logic [PWIDTH-1:0]  half;
   logic [PWIDTH-1:0]  sampleLast;
   logic               voteBit;

   logic [PWIDTH-1:0]  edgeCnt_q;
   logic [PWIDTH-1:0]  edgeCnt_d;
   logic [BCWIDTH-1:0] bitCnt_q;
   logic [BCWIDTH-1:0] bitCnt_d;
   logic               sampled_q;
   logic               sampled_d;

   sync_2ff #(
      .RESET_VAL (IDLE_LEVEL)
   ) uSync (
      .clk    (clk),
      .rst    (rst),
      .data_i (rx_in),
      .data_o (rxSync)
   );

   assign edgeLast   = prescale - PWIDTH'(1);
   assign half       = prescale >> 1;
   assign sampleLast = half + PWIDTH'(1);

`ifdef RX_MAJORITY_VOTE_EN
   logic [PWIDTH-1:0] sampleFirst;
   logic              earlyBit_q;
   logic              earlyBit_d;
   logic              midBit_q;
   logic              midBit_d;

   assign sampleFirst = half - PWIDTH'(1);

   // Early samples are dropped whenever the frame is abandoned so a stale bit never votes.
   always_comb begin
      earlyBit_d = earlyBit_q;
      midBit_d   = midBit_q;
      if (!enable) begin
         earlyBit_d = 1'b0;
         midBit_d   = 1'b0;
      end else begin
         if (edgeCnt_q == sampleFirst) begin
            earlyBit_d = rxSync;
         end
         if (edgeCnt_q == half) begin
            midBit_d = rxSync;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         earlyBit_q <= 1'b0;
         midBit_q   <= 1'b0;
      end else begin
         earlyBit_q <= earlyBit_d;
         midBit_q   <= midBit_d;
      end
   end

   assign voteBit = majority3(earlyBit_q, midBit_q, rxSync);
`else
   assign voteBit = rxSync;
`endif

   // The wrap test uses >= so an out-of-range count still returns to zero in one step.
   always_comb begin
      edgeCnt_d = edgeCnt_q;
      bitCnt_d  = bitCnt_q;
      sampled_d = sampled_q;
      if (!enable) begin
         edgeCnt_d = '0;
         bitCnt_d  = '0;
      end else begin
         if (edgeCnt_q >= edgeLast) begin
            edgeCnt_d = '0;
            bitCnt_d  = bitCnt_q + BCWIDTH'(1);
         end else begin
            edgeCnt_d = edgeCnt_q + PWIDTH'(1);
         end
         if (edgeCnt_q == sampleLast) begin
            sampled_d = voteBit;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         edgeCnt_q <= '0;
         bitCnt_q  <= '0;
         sampled_q <= IDLE_LEVEL;
      end else begin
         edgeCnt_q <= edgeCnt_d;
         bitCnt_q  <= bitCnt_d;
         sampled_q <= sampled_d;
      end
   end

   assign rx_sync      = rxSync;
   assign edge_counter = edgeCnt_q;
   assign bit_counter  = bitCnt_q;
   assign sampled_bit  = sampled_q;
   assign bit_done     = enable && (edgeCnt_q == edgeLast);

endmodule

// File: tb/tb_rx_data_sampler.sv
// Self-checking bench for rx_data_sampler: constant vector table, directed corner
// sequences and a randomized run, all compared against a cycle-count reference model.
module tb_rx_data_sampler;

   localparam int PW = 6;
   localparam int BW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic          rxIn;
   logic [PW-1:0] prescale;
   logic          rx_sync;
   logic [PW-1:0] edge_counter;
   logic [BW-1:0] bit_counter;
   logic          sampled_bit;
   logic          bit_done;

   int errors = 0;
   int checks = 0;

   // Reference model: position is derived from the number of consecutive enabled edges.
   int   runLen;
   logic mSampled;
   logic syncQ[$];
   logic posSamples[64];

   typedef struct {
      logic en;
      logic rx;
      int   expEdge;
      int   expBit;
      logic expDone;
      logic expSampled;
   } vector_t;

   vector_t vecs[11];

   rx_data_sampler #(
      .PWIDTH  (PW),
      .BCWIDTH (BW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .rx_in        (rxIn),
      .prescale     (prescale),
      .rx_sync      (rx_sync),
      .edge_counter (edge_counter),
      .bit_counter  (bit_counter),
      .sampled_bit  (sampled_bit),
      .bit_done     (bit_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic modelReset();
      runLen   = 0;
      mSampled = 1'b1;
      syncQ    = {1'b1, 1'b1};
      for (int i = 0; i < 64; i++) posSamples[i] = 1'b0;
   endtask

   task automatic modelEdge();
      int   ps;
      int   e;
      int   h;
      int   votes;
      logic rs;
      ps = int'(prescale);
      e  = runLen % ps;
      h  = ps / 2;
      rs = syncQ[0];
      if (enable) begin
         posSamples[e] = rs;
         if (e == h + 1) begin
`ifdef RX_MAJORITY_VOTE_EN
            votes    = int'(posSamples[h-1]) + int'(posSamples[h]) + int'(rs);
            mSampled = (votes >= 2);
`else
            votes    = 0;
            mSampled = rs;
`endif
         end
         runLen++;
      end else begin
         runLen = 0;
      end
      syncQ.push_back(rxIn);
      void'(syncQ.pop_front());
   endtask

   task automatic checkOutput();
      int ps;
      ps = int'(prescale);
      check("edge_counter", 32'(edge_counter), 32'(runLen % ps));
      check("bit_counter", 32'(bit_counter), 32'((runLen / ps) % 16));
      check("bit_done", 32'(bit_done), 32'(enable && (runLen % ps == ps - 1)));
      check("sampled_bit", 32'(sampled_bit), 32'(mSampled));
      check("rx_sync", 32'(rx_sync), 32'(syncQ[0]));
   endtask

   task automatic applyStimulus(input logic en, input logic rx);
      enable = en;
      rxIn   = rx;
      @(posedge clk);
      if (!rst) modelEdge();
      @(negedge clk);
      checkOutput();
   endtask

   task automatic pulseReset();
      #2 rst = 1'b1;
      modelReset();
      #1 checkOutput();
      check("rst_rx_sync", 32'(rx_sync), 32'd1);
      @(negedge clk);
      checkOutput();
      rst = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{1'b1, 1'b1, 1, 0, 1'b0, 1'b1};
      vecs[1]  = '{1'b1, 1'b1, 2, 0, 1'b0, 1'b1};
      vecs[2]  = '{1'b1, 1'b1, 3, 0, 1'b0, 1'b1};
      vecs[3]  = '{1'b1, 1'b1, 4, 0, 1'b0, 1'b1};
      vecs[4]  = '{1'b1, 1'b1, 5, 0, 1'b0, 1'b1};
      vecs[5]  = '{1'b1, 1'b1, 6, 0, 1'b0, 1'b1};
      vecs[6]  = '{1'b1, 1'b1, 7, 0, 1'b1, 1'b1};
      vecs[7]  = '{1'b1, 1'b1, 0, 1, 1'b0, 1'b1};
      vecs[8]  = '{1'b1, 1'b1, 1, 1, 1'b0, 1'b1};
      vecs[9]  = '{1'b0, 1'b1, 0, 0, 1'b0, 1'b1};
      vecs[10] = '{1'b1, 1'b1, 1, 0, 1'b0, 1'b1};

      rst      = 1'b1;
      enable   = 1'b0;
      rxIn     = 1'b1;
      prescale = PW'(8);
      modelReset();
      @(negedge clk);
      checkOutput();
      rst = 1'b0;

      // Table of constant vectors at prescale 8.
      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i].en, vecs[i].rx);
         check("vec_edge", 32'(edge_counter), 32'(vecs[i].expEdge));
         check("vec_bit", 32'(bit_counter), 32'(vecs[i].expBit));
         check("vec_done", 32'(bit_done), 32'(vecs[i].expDone));
         check("vec_sampled", 32'(sampled_bit), 32'(vecs[i].expSampled));
      end

      // 24 enabled cycles at prescale 8: three bit_done pulses, bit_counter lands on 3.
      begin
         int doneCount;
         doneCount = 0;
         applyStimulus(1'b0, 1'b1);
         for (int c = 1; c <= 24; c++) begin
            applyStimulus(1'b1, 1'b1);
            if (bit_done) doneCount++;
         end
         check("done_pulses", 32'(doneCount), 32'd3);
         check("bits_after_24", 32'(bit_counter), 32'd3);
         check("edge_after_24", 32'(edge_counter), 32'd0);
      end

      // Reset mid-count at edge 5 of bit 3 with the line low.
      for (int c = 0; c < 5; c++) applyStimulus(1'b1, 1'b0);
      check("pre_rst_edge", 32'(edge_counter), 32'd5);
      check("pre_rst_bit", 32'(bit_counter), 32'd3);
      check("pre_rst_sync", 32'(rx_sync), 32'd0);
      pulseReset();
      check("rst_edge", 32'(edge_counter), 32'd0);

      // Line toggling with enable low: synchroniser follows, counters stay at zero.
      for (int c = 0; c < 8; c++) begin
         applyStimulus(1'b0, logic'(c[1] ^ c[0]));
         check("idle_edge", 32'(edge_counter), 32'd0);
      end

      // prescale 16: steady 0 then steady 1, decided at edge 9 and visible at edge 10.
      prescale = PW'(16);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      for (int s = 1; s <= 32; s++) begin
         applyStimulus(1'b1, (s <= 12) ? 1'b0 : 1'b1);
         if (s == 9)  check("p16_before", 32'(sampled_bit), 32'd1);
         if (s == 10) check("p16_zero", 32'(sampled_bit), 32'd0);
         if (s == 26) check("p16_one", 32'(sampled_bit), 32'd1);
      end

      // Sample patterns at edges 3,4,5 with prescale 8.
      prescale = PW'(8);
      begin
         logic [2:0] pats[3];
         logic       expv[3];
         logic [2:0] pat;
         logic       rxv;
         pats[0] = 3'b110;
         pats[1] = 3'b001;
         pats[2] = 3'b010;
`ifdef RX_MAJORITY_VOTE_EN
         expv[0] = 1'b1; expv[1] = 1'b0; expv[2] = 1'b0;
`else
         expv[0] = 1'b0; expv[1] = 1'b1; expv[2] = 1'b0;
`endif
         for (int p = 0; p < 3; p++) begin
            pat = pats[p];
            applyStimulus(1'b0, 1'b1);
            applyStimulus(1'b0, 1'b1);
            for (int j = 1; j <= 8; j++) begin
               if (j + 1 == 3)      rxv = pat[2];
               else if (j + 1 == 4) rxv = pat[1];
               else if (j + 1 == 5) rxv = pat[0];
               else                 rxv = 1'b1;
               applyStimulus(1'b1, rxv);
               if (j == 6) check("vote_pattern", 32'(sampled_bit), 32'(expv[p]));
            end
         end
      end

      // Enable dropped at edge 2 of bit 4 abandons the bit.
      begin
         logic held;
         applyStimulus(1'b0, 1'b1);
         for (int c = 0; c < 34; c++) applyStimulus(1'b1, logic'($urandom_range(0, 1)));
         check("drop_pre_edge", 32'(edge_counter), 32'd2);
         check("drop_pre_bit", 32'(bit_counter), 32'd4);
         held = mSampled;
         applyStimulus(1'b0, 1'b1);
         check("drop_edge", 32'(edge_counter), 32'd0);
         check("drop_bit", 32'(bit_counter), 32'd0);
         check("drop_sampled", 32'(sampled_bit), 32'(held));
         check("drop_done", 32'(bit_done), 32'd0);
      end

      // Randomized run; prescale only changes while enable is low.
      begin
         logic en;
         logic rx;
         int   sel;
         en = 1'b0;
         rx = 1'b1;
         for (int c = 0; c < 600; c++) begin
            if (!en && $urandom_range(0, 3) == 0) begin
               sel = $urandom_range(0, 2);
               prescale = (sel == 0) ? PW'(8) : (sel == 1) ? PW'(16) : PW'(32);
            end
            en = ($urandom_range(0, 24) != 0);
            if ($urandom_range(0, 3) == 0) rx = ~rx;
            applyStimulus(en, rx);
            if ($urandom_range(0, 149) == 0) pulseReset();
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
